// File: rtl/csr_commit_ctrl_pkg.sv
// csr_commit_ctrl_pkg: shared widths, instruction kinds, FSM states and system-CSR constants
package csr_commit_ctrl_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [11:0] CSR_ADDR_MEPC  = 12'h341;
  localparam logic [11:0] CSR_ADDR_MTVEC = 12'h305;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;
  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_CSR,
    KIND_MRET,
    KIND_ECALL
  } csr_kind_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SYSJ,
    S_RESOLVE,
    S_DRAIN
  } ccs_state_t;
  function automatic logic [11:0] sys_csr_addr(input csr_kind_t k);
    return k == KIND_MRET ? CSR_ADDR_MEPC : CSR_ADDR_MTVEC;
  endfunction
endpackage

// File: rtl/csr_commit_ctrl_if.sv
// csr_commit_ctrl_if: ROB head, CSR file and commit-side signals of the CSR commit controller
interface csr_commit_ctrl_if #(
  parameter int PREG_W = 6
);
  import csr_commit_ctrl_pkg::*;
  logic                  head_valid;
  csr_kind_t             head_kind;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [11:0]           head_csr_addr;
  logic [2:0]            head_csr_op;
  logic [4:0]            head_csr_imm;
  logic [DATA_WIDTH-1:0] head_rs1_data;
  logic [PREG_W-1:0]     head_prd;
  logic                  head_rd_zero;
  logic [ADDR_WIDTH-1:0] idle_next_pc;
  logic                  rob_empty;
  logic                  ext_irq_in;
  logic                  tmr_irq_in;
  logic                  sft_irq_in;
  logic [11:0]           csr_addr;
  logic [2:0]            csr_op;
  logic [4:0]            csr_imm;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] csr_data_i;
  logic                  sys_jump;
  logic [11:0]           sys_jump_csr_addr;
  logic [ADDR_WIDTH-1:0] sys_jump_pc;
  logic [DATA_WIDTH-1:0] sys_jump_csr_data;
  logic                  ext_irq;
  logic                  tmr_irq;
  logic                  sft_irq;
  logic                  irq_taken;
  logic [ADDR_WIDTH-1:0] PC_handler;
  logic [ADDR_WIDTH-1:0] nxt_unexec_PC;
  logic                  retire;
  logic                  wb_valid;
  logic [PREG_W-1:0]     wb_prd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  flush;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  drain_err;
  modport slave (
    input  head_valid, head_kind, head_pc, head_csr_addr, head_csr_op, head_csr_imm,
           head_rs1_data, head_prd, head_rd_zero, idle_next_pc, rob_empty,
           ext_irq_in, tmr_irq_in, sft_irq_in, csr_data_i, sys_jump_csr_data,
           irq_taken, PC_handler,
    output csr_addr, csr_op, csr_imm, rs1_data, sys_jump, sys_jump_csr_addr, sys_jump_pc,
           ext_irq, tmr_irq, sft_irq, nxt_unexec_PC, retire, wb_valid, wb_prd, wb_data,
           flush, redirect_valid, redirect_pc, drain_err
  );
  modport master (
    output head_valid, head_kind, head_pc, head_csr_addr, head_csr_op, head_csr_imm,
           head_rs1_data, head_prd, head_rd_zero, idle_next_pc, rob_empty,
           ext_irq_in, tmr_irq_in, sft_irq_in, csr_data_i, sys_jump_csr_data,
           irq_taken, PC_handler,
    input  csr_addr, csr_op, csr_imm, rs1_data, sys_jump, sys_jump_csr_addr, sys_jump_pc,
           ext_irq, tmr_irq, sft_irq, nxt_unexec_PC, retire, wb_valid, wb_prd, wb_data,
           flush, redirect_valid, redirect_pc, drain_err
  );
endinterface

// File: rtl/csr_commit_ctrl_irq_gate.sv
// csr_irq_gate: blocks interrupts unless the controller is idle with no system instruction pending
module csr_irq_gate
  import csr_commit_ctrl_pkg::*;
(
  input  logic                  idle_i,
  input  logic                  head_valid_i,
  input  csr_kind_t             head_kind_i,
  input  logic [ADDR_WIDTH-1:0] head_pc_i,
  input  logic [ADDR_WIDTH-1:0] idle_next_pc_i,
  input  logic                  ext_irq_in_i,
  input  logic                  tmr_irq_in_i,
  input  logic                  sft_irq_in_i,
  output logic                  ext_irq_o,
  output logic                  tmr_irq_o,
  output logic                  sft_irq_o,
  output logic [ADDR_WIDTH-1:0] nxt_unexec_pc_o
);
  logic open_w;
  // interrupts only pass when nothing can write a CSR or jump in the same cycle
  always_comb begin
    open_w          = idle_i && !(head_valid_i && head_kind_i != KIND_NONE);
    ext_irq_o       = open_w && ext_irq_in_i;
    tmr_irq_o       = open_w && tmr_irq_in_i;
    sft_irq_o       = open_w && sft_irq_in_i;
    nxt_unexec_pc_o = head_valid_i ? head_pc_i : idle_next_pc_i;
  end
endmodule

// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl: serializes CSR/MRET/ECALL at the ROB head and sequences flush, redirect and drain
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter int PREG_W    = 6,
  parameter int DRAIN_MAX = 64
) (
  input logic              clk,
  input logic              rst,
  csr_commit_ctrl_if.slave bus
);
  localparam int CW = $clog2(DRAIN_MAX);
  ccs_state_t            state_q, state_d;
  csr_kind_t             kind_q, kind_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [11:0]           addr_q, addr_d;
  logic [2:0]            op_q, op_d;
  logic [4:0]            imm_q, imm_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
  logic [PREG_W-1:0]     prd_q, prd_d;
  logic                  rd_zero_q, rd_zero_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  exec_w, sysj_w, res_w, no_write_w;

  csr_irq_gate u_gate (
    .idle_i         (state_q == S_IDLE),
    .head_valid_i   (bus.head_valid),
    .head_kind_i    (bus.head_kind),
    .head_pc_i      (bus.head_pc),
    .idle_next_pc_i (bus.idle_next_pc),
    .ext_irq_in_i   (bus.ext_irq_in),
    .tmr_irq_in_i   (bus.tmr_irq_in),
    .sft_irq_in_i   (bus.sft_irq_in),
    .ext_irq_o      (bus.ext_irq),
    .tmr_irq_o      (bus.tmr_irq),
    .sft_irq_o      (bus.sft_irq),
    .nxt_unexec_pc_o(bus.nxt_unexec_PC)
  );

  // state and latched head fields; kind NONE after RESOLVE marks an interrupt
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      kind_q    <= KIND_NONE;
      pc_q      <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      prd_q     <= '0;
      rd_zero_q <= 1'b0;
      target_q  <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      prd_q     <= prd_d;
      rd_zero_q <= rd_zero_d;
      target_q  <= target_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // next-state sequencing: interrupt beats a pending head, every non-drain state lasts one cycle
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    op_d      = op_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    prd_d     = prd_q;
    rd_zero_d = rd_zero_q;
    target_d  = target_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.irq_taken) begin
          kind_d   = KIND_NONE;
          target_d = bus.PC_handler;
          state_d  = S_RESOLVE;
        end else if (bus.head_valid && bus.head_kind != KIND_NONE) begin
          kind_d    = bus.head_kind;
          pc_d      = bus.head_pc;
          addr_d    = bus.head_csr_addr;
          op_d      = bus.head_csr_op;
          imm_d     = bus.head_csr_imm;
          rs1_d     = bus.head_rs1_data;
          prd_d     = bus.head_prd;
          rd_zero_d = bus.head_rd_zero;
          state_d   = bus.head_kind == KIND_CSR ? S_EXEC : S_SYSJ;
        end
      end
      S_EXEC: begin
        rdata_d  = bus.csr_data_i;
        target_d = pc_q + ADDR_WIDTH'(4);
        state_d  = S_RESOLVE;
      end
      S_SYSJ: begin
        target_d = bus.sys_jump_csr_data;
        state_d  = S_RESOLVE;
      end
      S_RESOLVE: begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.rob_empty) state_d = S_IDLE;
        else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; set/clear with a zero source is a pure read, so the write op is suppressed
  always_comb begin
    exec_w                = state_q == S_EXEC;
    sysj_w                = state_q == S_SYSJ;
    res_w                 = state_q == S_RESOLVE;
    no_write_w            = (op_q[1:0] == CSR_OP_RS || op_q[1:0] == CSR_OP_RC) && imm_q == '0;
    bus.csr_addr          = exec_w ? addr_q : '0;
    bus.csr_imm           = exec_w ? imm_q : '0;
    bus.rs1_data          = exec_w ? rs1_q : '0;
    bus.csr_op            = exec_w && !no_write_w ? op_q : 3'b000;
    bus.sys_jump          = sysj_w;
    bus.sys_jump_csr_addr = sysj_w ? sys_csr_addr(kind_q) : '0;
    bus.sys_jump_pc       = sysj_w ? pc_q : '0;
    bus.flush             = res_w;
    bus.redirect_valid    = res_w;
    bus.redirect_pc       = res_w ? target_q : '0;
    bus.retire            = res_w && kind_q != KIND_NONE;
    bus.wb_valid          = res_w && kind_q == KIND_CSR && !rd_zero_q;
    bus.wb_prd            = bus.wb_valid ? prd_q : '0;
    bus.wb_data           = bus.wb_valid ? rdata_q : '0;
    bus.drain_err         = err_q;
  end
endmodule

// File: tb/tb_csr_commit_ctrl.sv
// tb_csr_commit_ctrl: vector table, random transactions against a rule model, and corner sequences
module tb_csr_commit_ctrl;
  import csr_commit_ctrl_pkg::*;
  localparam int DMAX = 64;
  typedef struct {
    csr_kind_t   kind;
    logic [31:0] pc;
    logic [11:0] addr;
    logic [2:0]  op;
    logic [4:0]  imm;
    logic [31:0] rs1;
    logic [5:0]  prd;
    logic        rdz;
    logic [31:0] rd_val;
    logic [31:0] jd;
    logic [2:0]  e_op;
    logic [31:0] e_redir;
    logic        e_wb;
    logic [11:0] e_sja;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;
  logic exp_err = 1'b0;
  vec_t tbl[8];
  logic [2:0] ops[6];

  csr_commit_ctrl_if #(.PREG_W(6)) bus ();
  csr_commit_ctrl #(.PREG_W(6), .DRAIN_MAX(DMAX)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] irqs();
    return 32'({bus.ext_irq, bus.tmr_irq, bus.sft_irq});
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic is_csr = v.kind == KIND_CSR;
    logic set_clr = (int'(v.op) % 4) >= 2;
    r.e_op    = (is_csr && !(set_clr && v.imm == 0)) ? v.op : 3'b000;
    r.e_redir = is_csr ? v.pc + 32'd4 : v.jd;
    r.e_wb    = is_csr && !v.rdz;
    r.e_sja   = v.kind == KIND_MRET ? 12'h341 : v.kind == KIND_ECALL ? 12'h305 : 12'h000;
    return r;
  endfunction

  task automatic drain_then_idle(input int dd);
    step();
    repeat (dd) begin
      @(negedge clk);
      chk("gate_drain", irqs(), 32'h0);
      step();
    end
    bus.rob_empty = 1'b1;
    @(negedge clk);
    chk("gate_drain_last", irqs(), 32'h0);
    step();
    bus.rob_empty = 1'b0;
    @(negedge clk);
    chk("gate_idle_open", irqs(), 32'h7);
    chk("drain_err", 32'(bus.drain_err), 32'(exp_err));
    bus.ext_irq_in = 1'b0;
    bus.tmr_irq_in = 1'b0;
    bus.sft_irq_in = 1'b0;
    step();
  endtask

  task automatic run_txn(input vec_t v, input int dd);
    bus.head_valid    = 1'b1;
    bus.head_kind     = v.kind;
    bus.head_pc       = v.pc;
    bus.head_csr_addr = v.addr;
    bus.head_csr_op   = v.op;
    bus.head_csr_imm  = v.imm;
    bus.head_rs1_data = v.rs1;
    bus.head_prd      = v.prd;
    bus.head_rd_zero  = v.rdz;
    bus.ext_irq_in    = 1'b1;
    bus.tmr_irq_in    = 1'b1;
    bus.sft_irq_in    = 1'b1;
    bus.rob_empty     = 1'b0;
    @(negedge clk);
    chk("gate_head_pending", irqs(), 32'h0);
    chk("nxt_unexec_pc_head", bus.nxt_unexec_PC, v.pc);
    step();
    bus.head_valid        = 1'b0;
    bus.head_kind         = KIND_NONE;
    bus.head_csr_addr     = 12'($urandom);
    bus.head_csr_op       = 3'($urandom);
    bus.head_csr_imm      = 5'($urandom);
    bus.csr_data_i        = v.rd_val;
    bus.sys_jump_csr_data = v.jd;
    @(negedge clk);
    chk("gate_busy", irqs(), 32'h0);
    chk("csr_op", 32'(bus.csr_op), 32'(v.e_op));
    chk("sys_jump", 32'(bus.sys_jump), 32'(v.kind != KIND_CSR));
    chk("sys_jump_csr_addr", 32'(bus.sys_jump_csr_addr), 32'(v.e_sja));
    if (v.kind == KIND_CSR) begin
      chk("csr_addr", 32'(bus.csr_addr), 32'(v.addr));
      chk("csr_imm", 32'(bus.csr_imm), 32'(v.imm));
      chk("rs1_data", bus.rs1_data, v.rs1);
    end else chk("sys_jump_pc", bus.sys_jump_pc, v.pc);
    step();
    bus.csr_data_i        = $urandom;
    bus.sys_jump_csr_data = $urandom;
    @(negedge clk);
    chk("flush", 32'(bus.flush), 32'h1);
    chk("redirect_valid", 32'(bus.redirect_valid), 32'h1);
    chk("redirect_pc", bus.redirect_pc, v.e_redir);
    chk("retire", 32'(bus.retire), 32'h1);
    chk("wb_valid", 32'(bus.wb_valid), 32'(v.e_wb));
    chk("csr_op_resolve", 32'(bus.csr_op), 32'h0);
    if (v.e_wb) begin
      chk("wb_data", bus.wb_data, v.rd_val);
      chk("wb_prd", 32'(bus.wb_prd), 32'(v.prd));
    end
    drain_then_idle(dd);
  endtask

  task automatic run_irq(input logic [31:0] handler, input int dd);
    bus.head_valid = 1'b0;
    bus.tmr_irq_in = 1'b1;
    bus.idle_next_pc = 32'h0000_0A00;
    @(negedge clk);
    chk("tmr_irq_pass", 32'(bus.tmr_irq), 32'h1);
    chk("ext_irq_quiet", 32'(bus.ext_irq), 32'h0);
    chk("nxt_unexec_pc_idle", bus.nxt_unexec_PC, 32'h0000_0A00);
    bus.irq_taken  = 1'b1;
    bus.PC_handler = handler;
    step();
    bus.irq_taken  = 1'b0;
    bus.PC_handler = $urandom;
    @(negedge clk);
    chk("irq_flush", 32'(bus.flush), 32'h1);
    chk("irq_redirect_pc", bus.redirect_pc, handler);
    chk("irq_retire", 32'(bus.retire), 32'h0);
    chk("irq_wb_valid", 32'(bus.wb_valid), 32'h0);
    bus.ext_irq_in = 1'b1;
    bus.sft_irq_in = 1'b1;
    drain_then_idle(dd);
  endtask

  initial begin
    vec_t v;
    int n;
    ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    tbl[0] = '{KIND_CSR, 32'h100, 12'h340, 3'b001, 5'd5, 32'hDEADBEEF, 6'd7, 1'b0, 32'h12, 32'h0, 3'b001, 32'h104, 1'b1, 12'h000};
    tbl[1] = '{KIND_CSR, 32'h180, 12'h300, 3'b010, 5'd0, 32'hFFFFFFFF, 6'd9, 1'b0, 32'h1800, 32'h0, 3'b000, 32'h184, 1'b1, 12'h000};
    tbl[2] = '{KIND_CSR, 32'h1A0, 12'h304, 3'b111, 5'd0, 32'h5, 6'd3, 1'b1, 32'h888, 32'h0, 3'b000, 32'h1A4, 1'b0, 12'h000};
    tbl[3] = '{KIND_CSR, 32'h1B0, 12'h344, 3'b110, 5'd3, 32'h0, 6'd12, 1'b0, 32'hA5A5, 32'h0, 3'b110, 32'h1B4, 1'b1, 12'h000};
    tbl[4] = '{KIND_CSR, 32'hFFFFFFFC, 12'h340, 3'b001, 5'd1, 32'h77, 6'd63, 1'b0, 32'h99, 32'h0, 3'b001, 32'h0, 1'b1, 12'h000};
    tbl[5] = '{KIND_MRET, 32'h200, 12'h0, 3'b000, 5'd0, 32'h0, 6'd1, 1'b0, 32'h0, 32'h80, 3'b000, 32'h80, 1'b0, 12'h341};
    tbl[6] = '{KIND_ECALL, 32'h204, 12'h0, 3'b000, 5'd0, 32'h0, 6'd2, 1'b1, 32'h0, 32'h1000, 3'b000, 32'h1000, 1'b0, 12'h305};
    tbl[7] = '{KIND_CSR, 32'h2000, 12'h305, 3'b011, 5'd1, 32'h3, 6'd5, 1'b0, 32'h7, 32'h0, 3'b011, 32'h2004, 1'b1, 12'h000};
    bus.head_valid = 1'b0; bus.head_kind = KIND_NONE; bus.head_pc = '0; bus.head_csr_addr = '0;
    bus.head_csr_op = '0; bus.head_csr_imm = '0; bus.head_rs1_data = '0; bus.head_prd = '0;
    bus.head_rd_zero = 1'b0; bus.idle_next_pc = '0; bus.rob_empty = 1'b0; bus.ext_irq_in = 1'b0;
    bus.tmr_irq_in = 1'b0; bus.sft_irq_in = 1'b0; bus.csr_data_i = '0; bus.sys_jump_csr_data = '0;
    bus.irq_taken = 1'b0; bus.PC_handler = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_retire", 32'(bus.retire), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
    chk("rst_csr_op", 32'(bus.csr_op), 32'h0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    chk("rst_sys_jump", 32'(bus.sys_jump), 32'h0);
    chk("rst_drain_err", 32'(bus.drain_err), 32'h0);
    rst = 1'b1;
    step();
    for (int i = 0; i < 8; i++) run_txn(tbl[i], i % 3);
    run_irq(32'h40, 0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) run_irq($urandom & 32'hFFFFFFFC, $urandom_range(0, 5));
      else begin
        v.kind   = csr_kind_t'(2'($urandom_range(1, 3)));
        v.pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
        v.addr   = 12'($urandom);
        v.op     = ops[$urandom_range(0, 5)];
        v.imm    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
        v.rs1    = $urandom;
        v.prd    = 6'($urandom);
        v.rdz    = 1'($urandom);
        v.rd_val = $urandom;
        v.jd     = $urandom;
        run_txn(model(v), $urandom_range(0, 5));
      end
    end
    bus.head_valid = 1'b1; bus.head_kind = KIND_ECALL; bus.head_pc = 32'h400;
    bus.sys_jump_csr_data = 32'h500; bus.rob_empty = 1'b0;
    step();
    bus.head_valid = 1'b0;
    step();
    @(negedge clk);
    chk("to_flush", 32'(bus.flush), 32'h1);
    n = 0;
    do begin
      step();
      n++;
      @(negedge clk);
    end while (!bus.drain_err && n < 200);
    chk("drain_cycles", 32'(n - 1), 32'(DMAX));
    chk("drain_err_set", 32'(bus.drain_err), 32'h1);
    exp_err = 1'b1;
    bus.tmr_irq_in = 1'b1;
    #1;
    chk("timeout_back_idle", 32'(bus.tmr_irq), 32'h1);
    bus.tmr_irq_in = 1'b0;
    step();
    run_txn(tbl[0], 0);
    chk("drain_err_sticky", 32'(bus.drain_err), 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    chk("drain_err_cleared", 32'(bus.drain_err), 32'h0);
    step();
    bus.head_valid = 1'b1; bus.head_kind = KIND_CSR; bus.head_pc = 32'h600;
    bus.head_csr_addr = 12'h340; bus.head_csr_op = 3'b001; bus.head_csr_imm = 5'd2;
    bus.head_rd_zero = 1'b0;
    step();
    bus.head_valid = 1'b0;
    @(negedge clk);
    chk("exec_before_rst", 32'(bus.csr_op), 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.tmr_irq_in = 1'b1;
    @(negedge clk);
    chk("rst_exec_retire", 32'(bus.retire), 32'h0);
    chk("rst_exec_wb_valid", 32'(bus.wb_valid), 32'h0);
    chk("rst_exec_flush", 32'(bus.flush), 32'h0);
    chk("rst_exec_csr_op", 32'(bus.csr_op), 32'h0);
    chk("rst_exec_idle", 32'(bus.tmr_irq), 32'h1);
    step();
    @(negedge clk);
    chk("rst_exec_no_resolve", 32'(bus.flush | bus.retire), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/csr_commit_ctrl.md
Name: csr_commit_ctrl

Overview:
- Serializes CSR, MRET and ECALL instructions at the ROB head and gates interrupt lines into the CSR file.
- Sits between the ROB retirement port and the CSR file. Drives the CSR file's csr_addr/csr_op/csr_imm/rs1_data, sys_jump*, nxt_unexec_PC and ext/tmr/sft_irq inputs, and consumes csr_data_o, sys_jump_csr_data, irq_taken and PC_handler.
- Produces destination write-back, head retire, pipeline flush and front-end redirect.

Parameters:
- PREG_W, 6, destination physical-register tag width.
- DRAIN_MAX, 64, cycle limit waiting for the back-end to drain after a flush.
- ADDR_WIDTH and DATA_WIDTH come from Falco_pkg (32).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets).
- head_valid  in  1  ROB head entry valid and complete.
- head_kind  in  2  csr_kind_t: NONE / CSR / MRET / ECALL.
- head_pc  in  ADDR_WIDTH  head instruction PC.
- head_csr_addr  in  12  CSR address.
- head_csr_op  in  3  funct3.
- head_csr_imm  in  5  zimm / rs1 index.
- head_rs1_data  in  DATA_WIDTH  rs1 operand.
- head_prd  in  PREG_W  destination tag.
- head_rd_zero  in  1  architectural rd is x0.
- idle_next_pc  in  ADDR_WIDTH  next fetch PC when ROB empty.
- rob_empty  in  1  back-end fully drained.
- ext_irq_in, tmr_irq_in, sft_irq_in  in  1 each  raw interrupt lines.
- csr_addr, csr_op, csr_imm, rs1_data  out  12/3/5/DATA_WIDTH  to CSR file.
- csr_data_i  in  DATA_WIDTH  CSR file read data.
- sys_jump, sys_jump_csr_addr, sys_jump_pc  out  1/12/ADDR_WIDTH  to CSR file.
- sys_jump_csr_data  in  DATA_WIDTH  jump target from CSR file.
- ext_irq, tmr_irq, sft_irq  out  1 each  gated interrupts to CSR file.
- irq_taken  in  1  from CSR file.
- PC_handler  in  ADDR_WIDTH  from CSR file.
- nxt_unexec_PC  out  ADDR_WIDTH  to CSR file.
- retire  out  1  pop ROB head.
- wb_valid, wb_prd, wb_data  out  1/PREG_W/DATA_WIDTH  write-back.
- flush  out  1  one-cycle pipeline flush.
- redirect_valid, redirect_pc  out  1/ADDR_WIDTH  fetch redirect.
- drain_err  out  1  sticky drain-timeout flag.

Behaviour:
- **States:** IDLE, EXEC, SYSJ, RESOLVE, DRAIN.
- **Reset:** state=IDLE. All outputs 0, csr_op=3'b000, drain counter 0, drain_err 0.
- **Interrupt gating:** *_irq = *_irq_in only when state==IDLE and !(head_valid && head_kind!=NONE); otherwise 0. This guarantees irq_taken never coincides with a CSR write or sys_jump.
- **nxt_unexec_PC:** head_pc if head_valid, else idle_next_pc (combinational).

IDLE:
- If irq_taken: latch target=PC_handler, go RESOLVE. Interrupt has priority.
- Else if head_valid and kind==CSR: latch head fields, go EXEC.
- Else if head_valid and kind is MRET/ECALL: latch, go SYSJ.
- Otherwise stay IDLE.

EXEC (exactly 1 cycle):
- Drive csr_addr/csr_imm/rs1_data from latch.
- csr_op = latched op, except forced to 3'b000 when op[1:0] is RS or RC and csr_imm==0 (read without write).
- Capture csr_data_i (pre-update value) into rdata; target = pc+4. Go RESOLVE.
- csr_op is 3'b000 in every other state.

SYSJ (exactly 1 cycle):
- Assert sys_jump, with sys_jump_csr_addr = 12'h341 for MRET and 12'h305 for ECALL, and sys_jump_pc = latched pc.
- Capture target = sys_jump_csr_data. Go RESOLVE.

RESOLVE (1 cycle):
- flush=1, redirect_valid=1, redirect_pc=target.
- retire=1 unless the cause was an interrupt.
- wb_valid=1 only for CSR with !rd_zero; wb_prd=latched tag, wb_data=rdata.
- Clear counter, go DRAIN.

DRAIN:
- Wait for rob_empty, then go IDLE.
- The counter increments each cycle. If it reaches DRAIN_MAX-1 without rob_empty, set drain_err (sticky until reset) and go IDLE.

Timing and boundary rules:
- Latency head→retire: CSR 2 cycles, MRET/ECALL 2 cycles, IRQ 1 cycle.
- pc+4 wraps modulo 2^ADDR_WIDTH.
- head_valid dropping while not in IDLE is ignored, because fields are latched.
- Reset in any state returns to IDLE next edge with no retire/flush/wb.

Decomposition:
- Falco_pkg gains csr_kind_t (NONE, CSR, MRET, ECALL), a ccs_state_t enum, CSR_ADDR_MEPC/CSR_ADDR_MTVEC constants and CSR_OP_RS/CSR_OP_RC codes.
- One natural sub-module, csr_irq_gate: combinational gating plus nxt_unexec_PC select.
- FSM and datapath stay in csr_commit_ctrl.

Test Plan:
- CSRRW, addr 0x340, rs1_data 0xDEADBEEF, old value 0x12, rd!=x0, pc 0x100:
  - EXEC drives op 3'b001.
  - RESOLVE: wb_data=0x12, retire=1, redirect_pc=0x104, flush=1.
- CSRRS with imm/rs1 index 0 on 0x300: csr_op stays 3'b000 throughout; wb_data = mstatus value; no write.
- MRET at pc 0x200, sys_jump_csr_data=0x80: sys_jump pulse with addr 0x341 → redirect_pc=0x80, retire=1, no wb.
- tmr_irq_in=1 in IDLE with head NONE, PC_handler=0x40:
  - tmr_irq passes through.
  - irq_taken → redirect_pc=0x40, retire=0.
  - tmr_irq_in while in EXEC yields tmr_irq=0.
- rob_empty held 0 after flush: drain_err=1 at cycle DRAIN_MAX, state returns IDLE; drain_err clears only on rst=0.
- rst=0 asserted during EXEC: next cycle IDLE, retire/wb_valid/flush all 0, csr_op=0.
